gpio_arb: RTL and testbench
===========================

GPIO_ARB -- requirements
Module: gpio_arb

Interface
REQ-001 The module SHALL have no parameters: data width 16 and register address width 2 are fixed to match the GPIO register block.
REQ-002 Port: clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 Port: rst  input  1  reset; synchronous and active-high.
REQ-004 Ports per requester n in {0,1}: req_n  input  1  request, held high until ack_n.
REQ-005 Ports per requester: op_n  input  2  operation: 00 write, 01 read, 10 set-bits, 11 clear-bits.
REQ-006 Ports per requester: addr_n  input  2  GPIO register address: 0 enable, 1 output, 2 input.
REQ-007 Ports per requester: wdata_n  input  16  write data or bit mask.
REQ-008 Ports per requester: ack_n  output  1  one-cycle completion pulse.
REQ-009 Ports per requester: err_n  output  1  valid with ack_n; high means the operation was rejected.
REQ-010 Port: rdata  output  16  read result, valid with ack_n of a read.
REQ-011 Ports: m_sel, m_wen  output  1 each  GPIO register-block select and write enable.
REQ-012 Port: m_addr  output  2  GPIO register-block address.
REQ-013 Port: m_datain  output  16  GPIO register-block write data.
REQ-014 Port: m_dataout  input  16  GPIO register-block read data.

Function
REQ-015 The FSM SHALL have states IDLE, ISSUE, CAPTURE and ACK.
REQ-016 In IDLE, with any req high, the FSM SHALL grant one requester, latch its op/addr/wdata and go to ISSUE next cycle.
- Grant: if both requesters are high, the one indicated by the round-robin pointer wins.
- Otherwise the single requester that is high wins.
REQ-017 In ISSUE, m_sel SHALL be 1 for exactly one cycle with m_addr and m_datain driven per REQ-019 to REQ-021.
- m_wen=1 for write, set-bits and clear-bits.
- m_wen=0 for read.
REQ-018 From ISSUE the FSM SHALL go to CAPTURE for a read and to ACK otherwise.
REQ-019 Write: m_addr=latched addr, m_datain=wdata.
REQ-020 Set-bits: m_addr=1, m_datain=shadow_out | wdata, regardless of addr_n.
REQ-021 Clear-bits: m_addr=1, m_datain=shadow_out & ~wdata, regardless of addr_n.
REQ-022 In CAPTURE, m_sel=1, m_wen=0 and m_addr=latched addr SHALL be held, and rdata SHALL register m_dataout at the end of the cycle.
REQ-023 In ACK, the granted requester's ack SHALL pulse for one cycle; the pointer SHALL then point to the other requester and the FSM SHALL return to IDLE.
REQ-024 Latency: write/set/clear ack SHALL be 2 cycles after the grant edge; read ack SHALL be 3 cycles after it.
REQ-025 Back-to-back: at most one transaction per 3 cycles (write) or 4 cycles (read); a new grant SHALL NOT occur in the ACK cycle.
REQ-026 Shadow registers shadow_en and shadow_out SHALL track every completed write to addr 0 and addr 1; set/clear SHALL update shadow_out.
REQ-027 A write or read to addr 3, or a write to addr 2, SHALL skip ISSUE: no m_sel, ack with err=1, shadows unchanged.
REQ-028 Outside ISSUE and CAPTURE, m_sel and m_wen SHALL be 0; m_addr and m_datain SHALL hold their last values.
REQ-029 rdata SHALL hold its value until the next read capture.
REQ-030 Dropping a req before it is granted SHALL cancel it; dropping it after the grant SHALL NOT abort the transaction.

Reset
REQ-031 With rst high at a clock edge, the following SHALL be set:
- FSM=IDLE, pointer=requester 0.
- All ack/err=0, m_sel=0, m_wen=0, m_addr=0, m_datain=0.
- rdata=0, shadow_en=0, shadow_out=0.
REQ-032 Reset asserted mid-transaction SHALL abort it with no ack; pending requesters SHALL re-request after reset.

Verification
REQ-033 Write: req_0, op=00, addr=0, wdata=0xFFFC -> one m_sel/m_wen cycle with m_addr=0, m_datain=0xFFFC; ack_0 two cycles after grant; shadow_en=0xFFFC.
REQ-034 Set/clear: after a write of 0x0007 to addr 1, do the following:
- set-bits mask 0x0100 -> m_datain=0x0107.
- Then clear-bits mask 0x0003 -> m_datain=0x0104, m_addr=1.
REQ-035 Read: m_dataout=0x0002, req_1 op=01 addr=2 -> m_sel two cycles with m_wen=0; rdata=0x0002 with ack_1 three cycles after grant.
REQ-036 Contention: req_0 and req_1 are both held continuously after reset -> grants alternate 0,1,0,1 with one transaction per 3 cycles (writes).
REQ-037 Error: write to addr 3 -> no m_sel; ack and err together one cycle after grant; shadows unchanged.
REQ-038 Reset mid-read: rst asserted in CAPTURE -> no ack, m_sel=0 the next cycle, rdata=0, pointer=0.

Source files
------------

// File: rtl/gpio_arb.sv
// -----------------------------------------------------------------------------
// gpio_arb
//
// Two-requester arbiter in front of a 16-bit GPIO register block. Each
// requester can write, read, set bits or clear bits in the block. Set and
// clear are turned into plain writes of the output register. The value
// written is built from a local shadow copy, so no read cycle is needed.
//
// Ports
//   clk, rst            single clock; synchronous active-high reset
//   req_n               request, held high by the requester until ack_n
//   op_n [1:0]          00 write, 01 read, 10 set-bits, 11 clear-bits
//   addr_n [1:0]        0 enable, 1 output, 2 input (3 is unmapped)
//   wdata_n [15:0]      write data or bit mask
//   ack_n               one-cycle completion pulse
//   err_n               valid with ack_n; high when the operation was rejected
//   rdata [15:0]        read result, valid with the ack of a read
//   m_sel, m_wen        register-block select / write enable
//   m_addr [1:0]        register-block address
//   m_datain [15:0]     register-block write data
//   m_dataout [15:0]    register-block read data
//
// Transaction timing, counted from the grant edge:
//   write/set/clear  IDLE -> ISSUE -> ACK -> IDLE   (ack seen 2 cycles later)
//   read             IDLE -> ISSUE -> CAPTURE -> ACK -> IDLE (ack after 3)
//   rejected op      IDLE -> ACK -> IDLE             (ack+err after 1)
// -----------------------------------------------------------------------------
module gpio_arb (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_0,
    input  logic [1:0]  op_0,
    input  logic [1:0]  addr_0,
    input  logic [15:0] wdata_0,
    output logic        ack_0,
    output logic        err_0,
    input  logic        req_1,
    input  logic [1:0]  op_1,
    input  logic [1:0]  addr_1,
    input  logic [15:0] wdata_1,
    output logic        ack_1,
    output logic        err_1,
    output logic [15:0] rdata,
    output logic        m_sel,
    output logic        m_wen,
    output logic [1:0]  m_addr,
    output logic [15:0] m_datain,
    input  logic [15:0] m_dataout
);

    localparam logic [1:0] OP_WR  = 2'b00;
    localparam logic [1:0] OP_RD  = 2'b01;
    localparam logic [1:0] OP_SET = 2'b10;
    localparam logic [1:0] OP_CLR = 2'b11;

    localparam logic [1:0] ADDR_EN  = 2'd0;
    localparam logic [1:0] ADDR_OUT = 2'd1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        ACK     = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        ptr_q, ptr_d;          // round-robin pointer: favoured requester
    logic        gnt_q, gnt_d;          // requester owning the current transaction
    logic [1:0]  op_q, op_d;
    logic [1:0]  ack_q, ack_d;
    logic [1:0]  err_q, err_d;
    logic        m_sel_q, m_sel_d;
    logic        m_wen_q, m_wen_d;
    logic [1:0]  m_addr_q, m_addr_d;
    logic [15:0] m_datain_q, m_datain_d;
    logic [15:0] rdata_q, rdata_d;
    logic [15:0] shadow_en_q, shadow_en_d;
    logic [15:0] shadow_out_q, shadow_out_d;

    // Requester-side inputs gathered into indexable form.
    logic [1:0]  req_vec;
    logic [1:0]  op_arr    [2];
    logic [1:0]  addr_arr  [2];
    logic [15:0] wdata_arr [2];

    assign req_vec      = {req_1, req_0};
    assign op_arr[0]    = op_0;
    assign op_arr[1]    = op_1;
    assign addr_arr[0]  = addr_0;
    assign addr_arr[1]  = addr_1;
    assign wdata_arr[0] = wdata_0;
    assign wdata_arr[1] = wdata_1;

    // Winner if a grant happens this cycle: the pointer only breaks ties.
    logic        sel;
    logic [1:0]  sel_op;
    logic [1:0]  sel_addr;
    logic [15:0] sel_wdata;
    logic        sel_bad;

    assign sel       = (&req_vec) ? ptr_q : req_vec[1];
    assign sel_op    = op_arr[sel];
    assign sel_addr  = addr_arr[sel];
    assign sel_wdata = wdata_arr[sel];

    // Address 3 is unmapped; address 2 (input register) is read-only.
    // Set/clear always target the output register, so they are never rejected.
    assign sel_bad = ((sel_op == OP_RD) && (sel_addr == 2'd3)) ||
                     ((sel_op == OP_WR) && sel_addr[1]);

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        gnt_d        = gnt_q;
        op_d         = op_q;
        ack_d        = 2'b00;
        err_d        = 2'b00;
        m_sel_d      = 1'b0;
        m_wen_d      = 1'b0;
        m_addr_d     = m_addr_q;
        m_datain_d   = m_datain_q;
        rdata_d      = rdata_q;
        shadow_en_d  = shadow_en_q;
        shadow_out_d = shadow_out_q;

        case (state_q)
            IDLE: begin
                if (|req_vec) begin
                    gnt_d = sel;
                    op_d  = sel_op;
                    if (sel_bad) begin
                        // Rejected: bus untouched, answer straight away.
                        state_d    = ACK;
                        ack_d[sel] = 1'b1;
                        err_d[sel] = 1'b1;
                    end else begin
                        state_d = ISSUE;
                        m_sel_d = 1'b1;
                        m_wen_d = (sel_op != OP_RD);
                        case (sel_op)
                            OP_WR: begin
                                m_addr_d   = sel_addr;
                                m_datain_d = sel_wdata;
                            end
                            OP_RD: begin
                                m_addr_d = sel_addr;
                            end
                            OP_SET: begin
                                m_addr_d   = ADDR_OUT;
                                m_datain_d = shadow_out_q | sel_wdata;
                            end
                            default: begin
                                m_addr_d   = ADDR_OUT;
                                m_datain_d = shadow_out_q & ~sel_wdata;
                            end
                        endcase
                    end
                end
            end

            ISSUE: begin
                if (op_q == OP_RD) begin
                    // Keep the read select up for a second cycle while the
                    // block presents its data.
                    state_d = CAPTURE;
                    m_sel_d = 1'b1;
                end else begin
                    state_d      = ACK;
                    ack_d[gnt_q] = 1'b1;
                    // The write has just been presented; mirror it locally so
                    // later set/clear operations start from the current value.
                    if (m_addr_q == ADDR_EN) begin
                        shadow_en_d = m_datain_q;
                    end
                    if (m_addr_q == ADDR_OUT) begin
                        shadow_out_d = m_datain_q;
                    end
                end
            end

            CAPTURE: begin
                state_d      = ACK;
                rdata_d      = m_dataout;
                ack_d[gnt_q] = 1'b1;
            end

            default: begin
                // ACK: the pulse is on the outputs now. No grant here, so the
                // other requester gets the first chance next time.
                state_d = IDLE;
                ptr_d   = ~gnt_q;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            ptr_q        <= 1'b0;
            gnt_q        <= 1'b0;
            op_q         <= OP_WR;
            ack_q        <= 2'b00;
            err_q        <= 2'b00;
            m_sel_q      <= 1'b0;
            m_wen_q      <= 1'b0;
            m_addr_q     <= 2'd0;
            m_datain_q   <= 16'h0000;
            rdata_q      <= 16'h0000;
            shadow_en_q  <= 16'h0000;
            shadow_out_q <= 16'h0000;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            gnt_q        <= gnt_d;
            op_q         <= op_d;
            ack_q        <= ack_d;
            err_q        <= err_d;
            m_sel_q      <= m_sel_d;
            m_wen_q      <= m_wen_d;
            m_addr_q     <= m_addr_d;
            m_datain_q   <= m_datain_d;
            rdata_q      <= rdata_d;
            shadow_en_q  <= shadow_en_d;
            shadow_out_q <= shadow_out_d;
        end
    end

    assign ack_0    = ack_q[0];
    assign ack_1    = ack_q[1];
    assign err_0    = err_q[0];
    assign err_1    = err_q[1];
    assign rdata    = rdata_q;
    assign m_sel    = m_sel_q;
    assign m_wen    = m_wen_q;
    assign m_addr   = m_addr_q;
    assign m_datain = m_datain_q;

endmodule

// File: tb/tb_gpio_arb.sv
// -----------------------------------------------------------------------------
// tb_gpio_arb
//
// Table of single transactions, each run to completion with its ack latency
// checked. A scoreboard holds the expected bus cycles and acks; a negedge
// monitor pops and compares them as the DUT produces them. Hand-written
// sequences cover reset in the middle of a read and continuous contention.
// -----------------------------------------------------------------------------
module tb_gpio_arb;

    localparam logic [1:0] OP_WR  = 2'b00;
    localparam logic [1:0] OP_RD  = 2'b01;
    localparam logic [1:0] OP_SET = 2'b10;
    localparam logic [1:0] OP_CLR = 2'b11;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_0 = 1'b0, req_1 = 1'b0;
    logic [1:0]  op_0 = 2'b00, op_1 = 2'b00;
    logic [1:0]  addr_0 = 2'b00, addr_1 = 2'b00;
    logic [15:0] wdata_0 = 16'h0, wdata_1 = 16'h0;
    logic        ack_0, ack_1, err_0, err_1;
    logic [15:0] rdata;
    logic        m_sel, m_wen;
    logic [1:0]  m_addr;
    logic [15:0] m_datain;
    logic [15:0] m_dataout = 16'h0;

    always #5 clk = ~clk;

    gpio_arb dut (
        .clk       (clk),
        .rst       (rst),
        .req_0     (req_0),
        .op_0      (op_0),
        .addr_0    (addr_0),
        .wdata_0   (wdata_0),
        .ack_0     (ack_0),
        .err_0     (err_0),
        .req_1     (req_1),
        .op_1      (op_1),
        .addr_1    (addr_1),
        .wdata_1   (wdata_1),
        .ack_1     (ack_1),
        .err_1     (err_1),
        .rdata     (rdata),
        .m_sel     (m_sel),
        .m_wen     (m_wen),
        .m_addr    (m_addr),
        .m_datain  (m_datain),
        .m_dataout (m_dataout)
    );

    typedef struct {
        logic        who;
        logic [1:0]  op;
        logic [1:0]  addr;
        logic [15:0] wdata;
        logic [15:0] dout;     // m_dataout presented during the transaction
        logic        drop;     // release req right after the grant
        logic        err;
        logic [1:0]  baddr;    // expected bus address of the write cycle
        logic [15:0] bdata;    // expected bus data of the write cycle
        logic        rd_chk;
        logic [15:0] rdata;
    } vec_t;

    typedef struct {
        logic        wen;
        logic [1:0]  addr;
        logic [15:0] data;
        logic        chk_data;
    } bus_t;

    typedef struct {
        logic        who;
        logic        err;
        logic        chk_rd;
        logic [15:0] rdata;
    } ack_t;

    bus_t bus_sb[$];
    ack_t ack_sb[$];

    int n_checks = 0;
    int n_fail   = 0;
    logic mon_on = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic who, input logic [1:0] op, input logic [1:0] addr,
                                input logic [15:0] wdata, input logic [15:0] dout,
                                input logic drop, input logic err, input logic [1:0] baddr,
                                input logic [15:0] bdata, input logic rd_chk,
                                input logic [15:0] rd);
        vec_t v;
        v.who = who; v.op = op; v.addr = addr; v.wdata = wdata; v.dout = dout;
        v.drop = drop; v.err = err; v.baddr = baddr; v.bdata = bdata;
        v.rd_chk = rd_chk; v.rdata = rd;
        return v;
    endfunction

    task automatic drive(input logic who, input logic r, input logic [1:0] op,
                         input logic [1:0] addr, input logic [15:0] wd);
        if (who) begin
            req_1 = r; op_1 = op; addr_1 = addr; wdata_1 = wd;
        end else begin
            req_0 = r; op_0 = op; addr_0 = addr; wdata_0 = wd;
        end
    endtask

    task automatic push_bus(input logic wen, input logic [1:0] addr, input logic [15:0] data,
                            input logic chk);
        bus_t b;
        b.wen = wen; b.addr = addr; b.data = data; b.chk_data = chk;
        bus_sb.push_back(b);
    endtask

    task automatic push_ack(input logic who, input logic err, input logic chk,
                            input logic [15:0] rd);
        ack_t a;
        a.who = who; a.err = err; a.chk_rd = chk; a.rdata = rd;
        ack_sb.push_back(a);
    endtask

    // One transaction from an idle DUT: called on a negedge, returns on a
    // negedge with the DUT back in IDLE.
    task automatic do_txn(input int idx, input vec_t v);
        int   lat;
        int   exp_lat;
        logic got;
        logic ackn;
        if (!v.err) begin
            if (v.op == OP_RD) begin
                push_bus(1'b0, v.addr, 16'h0, 1'b0);
                push_bus(1'b0, v.addr, 16'h0, 1'b0);
            end else begin
                push_bus(1'b1, v.baddr, v.bdata, 1'b1);
            end
        end
        push_ack(v.who, v.err, v.rd_chk, v.rdata);
        m_dataout = v.dout;
        drive(v.who, 1'b1, v.op, v.addr, v.wdata);
        exp_lat = v.err ? 1 : ((v.op == OP_RD) ? 3 : 2);
        lat = 0;
        got = 1'b0;
        for (int c = 1; c <= 8 && !got; c++) begin
            @(negedge clk);
            if (c == 1 && v.drop) drive(v.who, 1'b0, v.op, v.addr, v.wdata);
            ackn = v.who ? ack_1 : ack_0;
            if (ackn === 1'b1) begin
                got = 1'b1;
                lat = c;
            end
        end
        $display("txn %0d: req%0d op=%0d addr=%0d wdata=0x%04h latency=%0d rdata=0x%04h",
                 idx, v.who, v.op, v.addr, v.wdata, lat, rdata);
        check("ack_latency", lat, exp_lat);
        drive(v.who, 1'b0, v.op, v.addr, v.wdata);
        @(negedge clk);
        ackn = v.who ? ack_1 : ack_0;
        check("ack_one_cycle", ackn, 1'b0);
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        bus_t eb;
        ack_t ea;
        if (mon_on) begin
            check("err_without_ack", (err_0 & ~ack_0) | (err_1 & ~ack_1), 1'b0);
            check("wen_without_sel", m_wen & ~m_sel, 1'b0);
        end
        if (m_sel === 1'b1) begin
            if (bus_sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_m_sel: got m_sel=1 addr=%0d data=0x%04h, expected no bus cycle",
                         m_addr, m_datain);
            end else begin
                eb = bus_sb.pop_front();
                check("m_wen", m_wen, eb.wen);
                check("m_addr", m_addr, eb.addr);
                if (eb.chk_data) check("m_datain", m_datain, eb.data);
            end
        end
        if (ack_0 === 1'b1 || ack_1 === 1'b1) begin
            check("ack_exclusive", ack_0 & ack_1, 1'b0);
            if (ack_sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_ack: got ack_0=%0b ack_1=%0b, expected none", ack_0, ack_1);
            end else begin
                ea = ack_sb.pop_front();
                check("ack_owner", ack_1, ea.who);
                check("err", ea.who ? err_1 : err_0, ea.err);
                if (ea.chk_rd) check("rdata", rdata, ea.rdata);
            end
        end
    end

    vec_t tbl[14];

    initial begin
        int c;
        int prev;
        logic got;

        tbl[0]  = mk(0, OP_WR,  2'd0, 16'hFFFC, 16'h0000, 0, 0, 2'd0, 16'hFFFC, 0, 16'h0);
        tbl[1]  = mk(0, OP_WR,  2'd1, 16'h0007, 16'h0000, 0, 0, 2'd1, 16'h0007, 0, 16'h0);
        tbl[2]  = mk(1, OP_SET, 2'd2, 16'h0100, 16'h0000, 0, 0, 2'd1, 16'h0107, 0, 16'h0);
        tbl[3]  = mk(0, OP_CLR, 2'd0, 16'h0003, 16'h0000, 0, 0, 2'd1, 16'h0104, 0, 16'h0);
        tbl[4]  = mk(1, OP_RD,  2'd2, 16'h0000, 16'h0002, 0, 0, 2'd0, 16'h0000, 1, 16'h0002);
        tbl[5]  = mk(0, OP_WR,  2'd3, 16'hDEAD, 16'h0000, 0, 1, 2'd0, 16'h0000, 0, 16'h0);
        tbl[6]  = mk(1, OP_WR,  2'd2, 16'h1234, 16'h0000, 0, 1, 2'd0, 16'h0000, 0, 16'h0);
        tbl[7]  = mk(0, OP_RD,  2'd3, 16'h0000, 16'h5555, 0, 1, 2'd0, 16'h0000, 1, 16'h0002);
        tbl[8]  = mk(1, OP_SET, 2'd0, 16'h0000, 16'h0000, 0, 0, 2'd1, 16'h0104, 0, 16'h0);
        tbl[9]  = mk(0, OP_RD,  2'd1, 16'h0000, 16'hA5A5, 0, 0, 2'd0, 16'h0000, 1, 16'hA5A5);
        tbl[10] = mk(1, OP_RD,  2'd0, 16'h0000, 16'h0F0F, 1, 0, 2'd0, 16'h0000, 1, 16'h0F0F);
        tbl[11] = mk(0, OP_WR,  2'd1, 16'h8001, 16'h0000, 1, 0, 2'd1, 16'h8001, 0, 16'h0);
        tbl[12] = mk(1, OP_CLR, 2'd3, 16'h0001, 16'h0000, 0, 0, 2'd1, 16'h8000, 0, 16'h0);
        tbl[13] = mk(0, OP_WR,  2'd0, 16'h0055, 16'h0000, 0, 0, 2'd0, 16'h0055, 0, 16'h0);

        // Reset state.
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_ack_0", ack_0, 1'b0);
        check("rst_ack_1", ack_1, 1'b0);
        check("rst_err", {err_1, err_0}, 2'b00);
        check("rst_m_sel", m_sel, 1'b0);
        check("rst_m_wen", m_wen, 1'b0);
        check("rst_m_addr", m_addr, 2'd0);
        check("rst_m_datain", m_datain, 16'h0);
        check("rst_rdata", rdata, 16'h0);
        mon_on = 1'b1;
        rst = 1'b0;

        for (int i = 0; i < 14; i++) do_txn(i, tbl[i]);

        // Reset during CAPTURE of a read by requester 1: no ack, bus idle,
        // rdata cleared, pointer back to requester 0.
        push_bus(1'b0, 2'd0, 16'h0, 1'b0);
        push_bus(1'b0, 2'd0, 16'h0, 1'b0);
        m_dataout = 16'hBEEF;
        drive(1'b1, 1'b1, OP_RD, 2'd0, 16'h0);
        @(negedge clk);
        @(negedge clk);
        check("capture_m_sel", m_sel, 1'b1);
        rst = 1'b1;
        drive(1'b1, 1'b0, OP_RD, 2'd0, 16'h0);
        @(negedge clk);
        $display("txn reset-mid-read: m_sel=%0b ack=%0b%0b rdata=0x%04h", m_sel, ack_1, ack_0, rdata);
        check("midrst_m_sel", m_sel, 1'b0);
        check("midrst_ack", {ack_1, ack_0}, 2'b00);
        check("midrst_rdata", rdata, 16'h0);

        // Both requesters held continuously: grants alternate 0,1,0,1 with
        // one write every 3 cycles.
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            push_bus(1'b1, 2'd0, 16'h1111, 1'b1);
            push_ack(1'b0, 1'b0, 1'b0, 16'h0);
            push_bus(1'b1, 2'd1, 16'h2222, 1'b1);
            push_ack(1'b1, 1'b0, 1'b0, 16'h0);
        end
        drive(1'b0, 1'b1, OP_WR, 2'd0, 16'h1111);
        drive(1'b1, 1'b1, OP_WR, 2'd1, 16'h2222);
        c = 0;
        prev = 0;
        for (int k = 0; k < 4; k++) begin
            got = 1'b0;
            for (int t = 0; t < 10 && !got; t++) begin
                @(negedge clk);
                c++;
                if (ack_0 === 1'b1 || ack_1 === 1'b1) got = 1'b1;
            end
            $display("txn contention %0d: ack_0=%0b ack_1=%0b cycle=%0d", k, ack_0, ack_1, c);
            check("contention_gap", c - prev, (k == 0) ? 2 : 3);
            prev = c;
        end
        drive(1'b0, 1'b0, OP_WR, 2'd0, 16'h1111);
        drive(1'b1, 1'b0, OP_WR, 2'd1, 16'h2222);
        repeat (4) @(negedge clk);

        check("bus_sb_empty", bus_sb.size(), 0);
        check("ack_sb_empty", ack_sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
